phase_align: RTL and testbench

PHASE_ALIGN -- requirements
Module: phase_align

---
 rtl/phase_align.sv | 159 +++++++++++++++
 tb/tb_phase_align.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/phase_align.sv
`default_nettype none
// ============================================================================
// Module   : phase_align
// Purpose  : Word-boundary (phase) alignment for one TMDS channel. Looks for
//            runs of control tokens in the deserialized stream. If a full
//            window passes without a long enough run, it asks the deserializer
//            to bitslip. Once 2^CTKN_CNT_W consecutive tokens are seen, the
//            channel is declared aligned. Lock is dropped when a whole window
//            passes without any token.
// Ports    : clk        - sole clock, rising edge
//            rst_n      - asynchronous active-low reset
//            sdata      - raw 10-bit deserialized word
//            bitslip    - one-cycle request to shift the word boundary
//            psaligned  - registered "word boundary locked" flag
//            slip_cnt   - debug count of slips since last lock (0..9, wraps)
// Revision : 1.0 - initial release
// ============================================================================
module phase_align #(
    parameter int SRCH_TIMER_W = 12,
    parameter int CTKN_CNT_W   = 7,
    parameter int SLIP_WAIT    = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sdata,
    output logic       bitslip,
    output logic       psaligned,
    output logic [3:0] slip_cnt
);

    localparam logic [SRCH_TIMER_W-1:0] TIMER_MAX = '1;
    localparam logic [CTKN_CNT_W-1:0]   RUN_MAX   = '1;
    localparam int                      WAIT_W    = (SLIP_WAIT < 1) ? 1 : $clog2(SLIP_WAIT + 1);
    localparam logic [WAIT_W-1:0]       WAIT_LAST = WAIT_W'(SLIP_WAIT);

    localparam logic [9:0] CTRL_TOKEN0 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN1 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN2 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN3 = 10'b1010101011;

    typedef enum logic [2:0] {
        SEARCH  = 3'd0,
        BLNK    = 3'd1,
        SLIP    = 3'd2,
        WAIT    = 3'd3,
        ALIGNED = 3'd4
    } state_t;

    state_t                  state,     state_nxt;
    logic [SRCH_TIMER_W-1:0] timer,     timer_nxt;
    logic [CTKN_CNT_W-1:0]   run_cnt,   run_nxt;
    logic [WAIT_W-1:0]       wait_cnt,  wait_nxt;
    logic [3:0]              slip_nxt;
    logic                    token_q;
    logic                    token_hit;
    logic [SRCH_TIMER_W-1:0] timer_sat;

    assign token_hit = (sdata == CTRL_TOKEN0) || (sdata == CTRL_TOKEN1) ||
                       (sdata == CTRL_TOKEN2) || (sdata == CTRL_TOKEN3);

    // Timer never wraps on its own; only explicit clears bring it back to 0.
    assign timer_sat = (timer == TIMER_MAX) ? timer : timer + SRCH_TIMER_W'(1);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        run_nxt   = run_cnt;
        wait_nxt  = wait_cnt;
        slip_nxt  = slip_cnt;
        case (state)
            SEARCH: begin
                // A spent window wins over a fresh token: otherwise a stream
                // of short token runs (BLNK -> SEARCH -> BLNK ...) would only
                // ever reach SEARCH on a token and never slip.
                if (timer == TIMER_MAX) begin
                    state_nxt = SLIP;
                    slip_nxt  = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
                end else if (token_q) begin
                    state_nxt = BLNK;
                    run_nxt   = CTKN_CNT_W'(1);
                end else begin
                    timer_nxt = timer + SRCH_TIMER_W'(1);
                end
            end
            BLNK: begin
                // The window keeps running while a token run is counted.
                timer_nxt = timer_sat;
                if (token_q) begin
                    if (run_cnt == RUN_MAX) begin
                        state_nxt = ALIGNED;
                        timer_nxt = '0;
                        slip_nxt  = 4'd0;
                    end else begin
                        run_nxt = run_cnt + CTKN_CNT_W'(1);
                    end
                end else begin
                    state_nxt = SEARCH;
                end
            end
            SLIP: begin
                state_nxt = WAIT;
                wait_nxt  = '0;
            end
            WAIT: begin
                // Gives the deserializer time to settle after the slip.
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = SEARCH;
                    timer_nxt = '0;
                    run_nxt   = '0;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ALIGNED: begin
                if (token_q) begin
                    timer_nxt = '0;
                end else if (timer == TIMER_MAX) begin
                    state_nxt = SEARCH;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + SRCH_TIMER_W'(1);
                end
            end
            default: begin
                state_nxt = SEARCH;
                timer_nxt = '0;
                run_nxt   = '0;
                wait_nxt  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the very
    // edge the FSM enters or leaves SLIP / ALIGNED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            timer     <= '0;
            run_cnt   <= '0;
            wait_cnt  <= '0;
            slip_cnt  <= 4'd0;
            token_q   <= 1'b0;
            bitslip   <= 1'b0;
            psaligned <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            run_cnt   <= run_nxt;
            wait_cnt  <= wait_nxt;
            slip_cnt  <= slip_nxt;
            token_q   <= token_hit;
            bitslip   <= (state_nxt == SLIP);
            psaligned <= (state_nxt == ALIGNED);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phase_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_align
// Purpose  : Self-checking bench for phase_align (SRCH_TIMER_W=6,
//            CTKN_CNT_W=3, SLIP_WAIT=4). Expected output events (bitslip
//            pulses, psaligned edges) are queued with the edge number at
//            which they must appear; a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_align;

    localparam logic [9:0] TOK0   = 10'b1101010100;
    localparam logic [9:0] TOK1   = 10'b0010101011;
    localparam logic [9:0] TOK2   = 10'b0101010100;
    localparam logic [9:0] TOK3   = 10'b1010101011;
    localparam logic [9:0] NONTOK = 10'h155;

    localparam int EV_SLIP = 0;
    localparam int EV_RISE = 1;
    localparam int EV_FALL = 2;

    typedef struct {
        int cyc;
        int kind;
        int cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] sdata;
    logic       bitslip;
    logic       psaligned;
    logic [3:0] slip_cnt;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    ev_t exp_q[$];
    logic prev_ps = 1'b0;
    logic prev_bs = 1'b0;
    logic [9:0] toks [4];

    phase_align #(
        .SRCH_TIMER_W(6),
        .CTKN_CNT_W  (3),
        .SLIP_WAIT   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sdata    (sdata),
        .bitslip  (bitslip),
        .psaligned(psaligned),
        .slip_cnt (slip_cnt)
    );

    always #5 clk = ~clk;

    // Edge number since reset release: the first rising edge after release is 1.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input int k, input int n);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.cnt  = n;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: kind=%0d at edge %0d slip_cnt=%0d, none expected",
                     kind, cyc, slip_cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.cnt != int'(slip_cnt)) begin
                bad++;
                $display("FAIL event: got kind=%0d edge=%0d slip_cnt=%0d, expected kind=%0d edge=%0d slip_cnt=%0d",
                         kind, cyc, slip_cnt, e.kind, e.cyc, e.cnt);
            end
        end
    endtask

    // Monitor: compares every output event against the scoreboard and checks
    // that bitslip is never back-to-back nor raised while locked.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bitslip) observe(EV_SLIP);
            if (psaligned != prev_ps) observe(psaligned ? EV_RISE : EV_FALL);
            chk("bitslip_legal", int'(bitslip && (prev_bs || psaligned)), 0);
        end
        prev_ps = psaligned;
        prev_bs = bitslip;
    end

    task automatic drain(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: %0d expected events not seen, next edge=%0d kind=%0d",
                     name, exp_q.size(), exp_q[0].cyc, exp_q[0].kind);
            exp_q.delete();
        end
    endtask

    function automatic logic [9:0] word(input int mode, input int gap, input int e);
        case (mode)
            0:       return TOK0;
            1:       return NONTOK;
            2:       return (((e - 1) % 8) < 7) ? toks[e % 4] : NONTOK;
            3:       return (e <= 20) ? TOK0 : NONTOK;
            default: return (e <= 20 || ((e - 20) % gap) == 0) ? toks[e % 4] : NONTOK;
        endcase
    endfunction

    // Drive sdata for edge cyc+1 at each falling edge until edge n is done.
    task automatic run(input int mode, input int gap, input int n);
        while (cyc < n) begin
            sdata = word(mode, gap, cyc + 1);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bitslip", int'(bitslip), 0);
        chk("rst_psaligned", int'(psaligned), 0);
        chk("rst_slip_cnt", int'(slip_cnt), 0);
        rst_n = 1'b1;
    endtask

    task automatic async_reset_check(input string name);
        #1 rst_n = 1'b0;
        #1;
        chk({name, "_bitslip"}, int'(bitslip), 0);
        chk({name, "_psaligned"}, int'(psaligned), 0);
        chk({name, "_slip_cnt"}, int'(slip_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        toks[0] = TOK0;
        toks[1] = TOK1;
        toks[2] = TOK2;
        toks[3] = TOK3;
        rst_n = 1'b0;
        sdata = NONTOK;

        // Continuous token: 8 tokens sampled on edges 1..8, lock on edge 9.
        do_reset();
        push(9, EV_RISE, 0);
        run(0, 0, 20);
        chk("lock_slip_cnt", int'(slip_cnt), 0);
        drain("lock");

        // No tokens: slip at edge 64 then every 70 edges, counter 1..9,0.
        do_reset();
        for (int k = 0; k < 10; k++) push(64 + 70 * k, EV_SLIP, (k + 1) % 10);
        run(1, 0, 700);
        drain("noise");

        // 7 tokens + 1 non-token: run never completes, window still expires.
        do_reset();
        push(74, EV_SLIP, 1);
        push(154, EV_SLIP, 2);
        push(234, EV_SLIP, 3);
        run(2, 0, 240);
        drain("short_runs");

        // Lock, then 64 non-tokens: lose lock at edge 85, slip at 149.
        do_reset();
        push(9, EV_RISE, 0);
        push(85, EV_FALL, 0);
        push(149, EV_SLIP, 1);
        run(3, 0, 150);
        drain("loss");

        // Sparse tokens (gap 60, and gap 64 = 63 non-tokens) keep the lock.
        for (int g = 60; g <= 64; g += 4) begin
            do_reset();
            push(9, EV_RISE, 0);
            run(4, g, 260);
            chk("sparse_hold", int'(psaligned), 1);
            drain("sparse");
        end

        // Reset during the SLIP cycle, then re-lock.
        do_reset();
        push(64, EV_SLIP, 1);
        run(1, 0, 64);
        async_reset_check("rst_in_slip");
        drain("rst_slip");
        push(9, EV_RISE, 0);
        run(0, 0, 15);

        // Reset while aligned, then re-lock.
        async_reset_check("rst_in_aligned");
        drain("rst_aligned");
        push(9, EV_RISE, 0);
        run(0, 0, 12);
        chk("relock", int'(psaligned), 1);
        drain("relock");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
